// File: rtl/inv_shift_rows_stage.sv
// AES InvShiftRows stage with a 2-entry elastic buffer and valid/ready handshakes.
// Optional macro SHIFT_ROWS_DIR_EN adds a dir input selecting forward ShiftRows per state.
module inv_shift_rows_stage #(
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
`ifdef SHIFT_ROWS_DIR_EN
  input  logic              dir,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_in_ready;
  logic              r_out_valid;

  logic              w_push;
  logic              w_pop;
  logic              w_fwd;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_perm;

  // Byte k sits at row k%4, column k/4; byte 0 is the MSB. Each row r rotates by r columns.
  function automatic logic [DATA_W-1:0] shift_rows(input logic [DATA_W-1:0] s,
                                                   input logic             fwd);
    logic [DATA_W-1:0] o;
    logic [1:0]        src_c;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src_c = fwd ? 2'(c + r) : 2'(c - r);
        o[BYTE_W*(15-r-4*c) +: BYTE_W] = s[BYTE_W*(15-r-4*int'(src_c)) +: BYTE_W];
      end
    end
    return o;
  endfunction

`ifdef SHIFT_ROWS_DIR_EN
  assign w_fwd = dir;
`else
  assign w_fwd = 1'b0;
`endif

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;
  assign w_perm = shift_rows(in_data, w_fwd);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Handshake flags are precomputed from the next count so they leave straight from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_perm;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign occupancy = r_count;

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Bench for inv_shift_rows_stage: vector table, handshake corner sequences and a random soak.
module tb_inv_shift_rows_stage;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [1:0]   occupancy;
  logic         dir_t;

  int total;
  int bad;

  typedef struct {
    logic [127:0] din;
    logic         dir;
    logic [127:0] dout;
  } vec_t;

  vec_t         tbl[$];
  logic [127:0] exp_q[$];

  inv_shift_rows_stage #(.DATA_W(128)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SHIFT_ROWS_DIR_EN
    .dir       (dir_t),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lay the state out as rows and rotate each row with queue operations.
  function automatic logic [127:0] ref_perm(input logic [127:0] s, input logic fwd);
    logic [7:0]   row[$];
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      row = {};
      for (int c = 0; c < 4; c++) row.push_back(s[127-8*(r+4*c) -: 8]);
      for (int k = 0; k < r; k++) begin
        if (fwd) row.push_back(row.pop_front());
        else     row.push_front(row.pop_back());
      end
      for (int c = 0; c < 4; c++) o[127-8*(r+4*c) -: 8] = row[c];
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] a, b, c, d;
    int           sz;
    logic         push, pop;
    total     = 0;
    bad       = 0;
    dir_t     = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand128();
    out_ready = 1'b1;
    reset     = 1'b0;

    tbl.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                    128'h000d0a0704010e0b0805020f0c090603});
    tbl.push_back('{128'h00112233445566778899aabbccddeeff, 1'b0,
                    128'h00ddaa774411eebb885522ffcc996633});
    tbl.push_back('{128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                    128'h0f0205080b0e0104070a0d000306090c});
    tbl.push_back('{128'hffffffffffffffffffffffffffffffff, 1'b0,
                    128'hffffffffffffffffffffffffffffffff});
`ifdef SHIFT_ROWS_DIR_EN
    tbl.push_back('{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                    128'h00050a0f04090e03080d02070c01060b});
    tbl.push_back('{128'h00050a0f04090e03080d02070c01060b, 1'b0,
                    128'h000102030405060708090a0b0c0d0e0f});
`endif

    // Reset held two cycles with in_valid high.
    step();
    step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    reset    = 1'b1;
    in_valid = 1'b0;
    step();

    // Table vectors: one push each, visible for exactly one cycle.
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_data  = tbl[i].din;
      dir_t    = tbl[i].dir;
      step();
      in_valid = 1'b0;
      dir_t    = 1'b0;
      chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'(1));
      chk($sformatf("vec%0d_data", i), out_data, tbl[i].dout);
      chk($sformatf("vec%0d_occ", i), 128'(occupancy), 128'(1));
      step();
      chk($sformatf("vec%0d_drop", i), 128'(out_valid), 128'(0));
    end

    // Backpressure: fill, ignored third push, drain in order.
    a = rand128(); b = rand128(); c = rand128();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    step();
    in_data = b;
    step();
    chk("full_occ", 128'(occupancy), 128'(2));
    chk("full_in_ready", 128'(in_ready), 128'(0));
    in_data = c;
    step();
    chk("full_ignore_occ", 128'(occupancy), 128'(2));
    chk("full_hold_data", out_data, ref_perm(a, 1'b0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("drain_b_data", out_data, ref_perm(b, 1'b0));
    chk("drain_b_occ", 128'(occupancy), 128'(1));
    step();
    chk("drain_empty_valid", 128'(out_valid), 128'(0));
    chk("drain_empty_occ", 128'(occupancy), 128'(0));

    // Streaming 8 states back to back.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = rand128();
      exp_q.push_back(ref_perm(in_data, 1'b0));
      step();
      chk($sformatf("stream%0d_valid", i), 128'(out_valid), 128'(1));
      chk($sformatf("stream%0d_occ", i), 128'(occupancy), 128'(1));
      chk($sformatf("stream%0d_data", i), out_data, exp_q.pop_front());
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_occ", 128'(occupancy), 128'(0));

    // Reset while full discards both states.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand128();
    step();
    in_data = rand128();
    step();
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_occ", 128'(occupancy), 128'(0));
    chk("midrst_valid", 128'(out_valid), 128'(0));
    chk("midrst_data", out_data, 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    d         = rand128();
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("postrst_data", out_data, ref_perm(d, 1'b0));
    step();
    chk("postrst_empty", 128'(out_valid), 128'(0));

    // Random soak against the queue model.
    exp_q = {};
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_data   = rand128();
`ifdef SHIFT_ROWS_DIR_EN
      dir_t = 1'($urandom_range(0, 1));
`endif
      sz   = exp_q.size();
      push = in_valid && (sz < 2);
      pop  = out_ready && (sz > 0);
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(ref_perm(in_data, dir_t));
      step();
      sz = exp_q.size();
      chk($sformatf("rnd%0d_occ", i), 128'(occupancy), 128'(sz));
      chk($sformatf("rnd%0d_valid", i), 128'(out_valid), 128'(sz != 0));
      chk($sformatf("rnd%0d_in_ready", i), 128'(in_ready), 128'(sz != 2));
      if (sz > 0) chk($sformatf("rnd%0d_data", i), out_data, exp_q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
